// File: rtl/addsub_seq_if.sv
// Request/result handshake bundle for the byte-serial adder/subtractor.
// The requester drives the master side; addsub_seq sits on the slave side.
interface addsub_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_n;
    logic             out_z;
    logic             out_c;
    logic             out_v;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v
    );
endinterface

// File: rtl/addsub_seq.sv
// Sequential WIDTH-bit adder/subtractor that reuses one 8-bit carry slice over
// WIDTH/8 cycles, producing the sum plus N/Z/C/V flags behind a valid/ready pair.
module addsub_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    addsub_seq_if.slave  bus
);
    localparam int BEATS  = WIDTH / 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [BEATS-1:0][7:0]  r_a;
    logic [BEATS-1:0][7:0]  r_b;
    logic [BEATS-1:0][7:0]  r_sum;
    logic [BEATS-1:0][7:0]  w_sumFinal;
    logic [BEAT_W-1:0]      r_beat;
    logic                   r_carry;
    logic [8:0]             w_slice;
    logic                   w_msbCarryIn;
    logic                   w_lastBeat;
    logic                   w_accept;
    logic                   w_inReady;
    logic [WIDTH-1:0]       r_outSum;
    logic                   r_outValid;
    logic                   r_outN;
    logic                   r_outZ;
    logic                   r_outC;
    logic                   r_outV;

    assign w_inReady  = (r_state == IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_inReady;
    assign w_lastBeat = (r_beat == BEAT_W'(BEATS - 1));

    // The only adder in the block: one byte of A, one byte of B_eff and the running carry.
    assign w_slice      = {1'b0, r_a[r_beat]} + {1'b0, r_b[r_beat]} + {8'd0, r_carry};
    assign w_msbCarryIn = r_a[r_beat][7] ^ r_b[r_beat][7] ^ w_slice[7];

    always_comb begin
        w_sumFinal         = r_sum;
        w_sumFinal[r_beat] = w_slice[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_stateNext = RUN;
            RUN:     if (w_lastBeat)    w_stateNext = DONE;
            DONE:    if (bus.out_ready) w_stateNext = IDLE;
            default:                    w_stateNext = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in as the first carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_beat     <= '0;
            r_carry    <= 1'b0;
            r_outSum   <= '0;
            r_outValid <= 1'b0;
            r_outN     <= 1'b0;
            r_outZ     <= 1'b0;
            r_outC     <= 1'b0;
            r_outV     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b ^ {WIDTH{bus.in_sub}};
                        r_carry <= bus.in_sub;
                        r_beat  <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= w_sumFinal;
                    r_carry <= w_slice[8];
                    r_beat  <= w_lastBeat ? '0 : r_beat + 1'b1;
                    if (w_lastBeat) begin
                        r_outSum   <= w_sumFinal;
                        r_outN     <= w_slice[7];
                        r_outZ     <= (w_sumFinal == '0);
                        r_outC     <= w_slice[8];
                        r_outV     <= w_msbCarryIn ^ w_slice[8];
                        r_outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_sum   = r_outSum;
    assign bus.out_n     = r_outN;
    assign bus.out_z     = r_outZ;
    assign bus.out_c     = r_outC;
    assign bus.out_v     = r_outV;
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: an arithmetic reference model checks every output on every
// cycle, and directed scenarios pin the model with hand-computed results.
module tb_addsub_seq;
    localparam int WIDTH = 32;
    localparam int BEATS = WIDTH / 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;
    int   tbCyc   = 0;

    addsub_seq_if #(.WIDTH(WIDTH)) bus ();

    addsub_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tbCyc++;

    task automatic compareField(input string name, input logic [WIDTH-1:0] act,
                                input logic [WIDTH-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, tbCyc);
        end
    endtask

    // Plain full-width arithmetic: the result the serial datapath must reproduce.
    function automatic res_t modelResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic sub);
        res_t             r;
        logic [WIDTH-1:0] bEff;
        logic [WIDTH:0]   full;
        bEff  = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bEff} + (WIDTH + 1)'(sub);
        r.sum = full[WIDTH-1:0];
        r.c   = full[WIDTH];
        r.n   = r.sum[WIDTH-1];
        r.z   = (r.sum == '0);
        r.v   = (a[WIDTH-1] == bEff[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    res_t mPending   = '0;
    res_t mHeld      = '0;
    logic mBusy      = 1'b0;
    int   mAcceptCyc = -100;
    int   mCyc       = 0;

    // Model: one operation in flight, result visible BEATS+1 cycles after accept,
    // registers hold until the next result or a reset.
    always @(negedge clk) begin : cmpProc
        logic expValid;
        logic expReady;
        mCyc++;
        expValid = mBusy && ((mCyc - mAcceptCyc) >= BEATS + 1);
        if (expValid) mHeld = mPending;
        expReady = !mBusy && !rst;
        compareField("in_ready",  WIDTH'(bus.in_ready),  WIDTH'(expReady));
        compareField("out_valid", WIDTH'(bus.out_valid), WIDTH'(expValid));
        compareField("out_sum",   bus.out_sum,           mHeld.sum);
        compareField("out_n",     WIDTH'(bus.out_n),     WIDTH'(mHeld.n));
        compareField("out_z",     WIDTH'(bus.out_z),     WIDTH'(mHeld.z));
        compareField("out_c",     WIDTH'(bus.out_c),     WIDTH'(mHeld.c));
        compareField("out_v",     WIDTH'(bus.out_v),     WIDTH'(mHeld.v));
        if (rst) begin
            mBusy = 1'b0;
            mHeld = '0;
        end else if (bus.in_valid && expReady) begin
            mBusy      = 1'b1;
            mAcceptCyc = mCyc;
            mPending   = modelResult(bus.in_a, bus.in_b, bus.in_sub);
        end else if (expValid && bus.out_ready) begin
            mBusy = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
        int waited = 0;
        @(posedge clk);
        #1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        compareField("accepted", WIDTH'(bus.in_ready), WIDTH'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expSum,
                               input logic n, input logic z, input logic c, input logic v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 30);
        compareField({name, "_latency"}, WIDTH'(k), WIDTH'(BEATS + 1));
        compareField({name, "_sum"}, bus.out_sum, expSum);
        compareField({name, "_n"}, WIDTH'(bus.out_n), WIDTH'(n));
        compareField({name, "_z"}, WIDTH'(bus.out_z), WIDTH'(z));
        compareField({name, "_c"}, WIDTH'(bus.out_c), WIDTH'(c));
        compareField({name, "_v"}, WIDTH'(bus.out_v), WIDTH'(v));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH - 1){1'b0}}};
            3:       return {1'b0, {(WIDTH - 1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1;
        int t2;
        int w;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compareField("ready_after_reset", WIDTH'(bus.in_ready), WIDTH'(1));

        // Directed arithmetic corners with hand-computed results.
        applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        checkOutput("add_wrap", 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
        checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1);
        checkOutput("sub_neg", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure with a busy requester hammering in_valid.
        bus.out_ready = 1'b0;
        applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.out_valid && w < 30);
        compareField("bp_valid", WIDTH'(bus.out_valid), WIDTH'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_a     = WIDTH'($urandom);
            bus.in_b     = WIDTH'($urandom);
            bus.in_sub   = 1'($urandom_range(0, 1));
            @(negedge clk);
            compareField("bp_hold_sum", bus.out_sum, 32'h2143_6587);
            compareField("bp_hold_ready", WIDTH'(bus.in_ready), WIDTH'(0));
            compareField("bp_hold_valid", WIDTH'(bus.out_valid), WIDTH'(1));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        compareField("bp_xfer_valid", WIDTH'(bus.out_valid), WIDTH'(1));
        @(negedge clk);
        compareField("bp_after_ready", WIDTH'(bus.in_ready), WIDTH'(1));
        compareField("bp_after_valid", WIDTH'(bus.out_valid), WIDTH'(0));
        compareField("bp_after_sum", bus.out_sum, 32'h2143_6587);

        // Reset pulse while the third beat is being computed.
        applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        compareField("rst_ready_low", WIDTH'(bus.in_ready), WIDTH'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compareField("rst_ready", WIDTH'(bus.in_ready), WIDTH'(1));
        compareField("rst_valid", WIDTH'(bus.out_valid), WIDTH'(0));
        compareField("rst_sum", bus.out_sum, '0);
        compareField("rst_flags", WIDTH'({bus.out_n, bus.out_z, bus.out_c, bus.out_v}), '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            compareField("rst_no_result", WIDTH'(bus.out_valid), WIDTH'(0));
        end

        // Back-to-back requests held on in_valid.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_a      = 32'h0000_00FF;
        bus.in_b      = 32'h0000_0001;
        bus.in_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        t1 = tbCyc;
        @(posedge clk);
        #1;
        bus.in_a   = 32'h0000_0100;
        bus.in_b   = 32'h0000_0001;
        bus.in_sub = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        t2 = tbCyc;
        compareField("b2b_spacing", WIDTH'(t2 - t1), WIDTH'(BEATS + 2));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("b2b_second", 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic, occasional resets, random backpressure.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_a      = pickOperand();
            bus.in_b      = pickOperand();
            bus.in_sub    = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Derived constant: BEATS = WIDTH/8, the number of 8-bit slice operations per request.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  requester presents an operation.
REQ-006 Port: in_ready  output  1  block can accept an operation.
REQ-007 Port: in_a  input  WIDTH  operand A.
REQ-008 Port: in_b  input  WIDTH  operand B.
REQ-009 Port: in_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 Port: out_valid  output  1  result and flags are valid.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: out_sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 Port: out_n, out_z, out_c, out_v  output  1 each  negative, zero, carry and overflow flags.

Function
REQ-014 The block SHALL contain a single 8-bit add slice with carry-in, and SHALL reuse it over BEATS cycles per operation; no WIDTH-wide adder is permitted.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal (state==IDLE && !rst); it is a combinational output with no dependence on in_valid.
REQ-017 IDLE, on in_valid&&in_ready: capture in_a, B_eff = in_b XOR {WIDTH{in_sub}}, and in_sub; set carry = in_sub and beat = 0; go to RUN.
REQ-018 Inputs outside an accepted handshake SHALL be ignored; in_valid while not in IDLE SHALL have no effect.
REQ-019 RUN, each cycle: slice result = A[8*beat+:8] + B_eff[8*beat+:8] + carry; write it to sum[8*beat+:8]; carry <= slice carry-out; beat <= beat+1.
REQ-020 RUN, on beat==BEATS-1: register out_sum and all flags, set out_valid, go to DONE.
REQ-021 Latency: handshake in cycle 0, RUN in cycles 1..BEATS, out_valid high from cycle BEATS+1 (cycle 5 for WIDTH=32).
REQ-022 Flags: out_n = sum[WIDTH-1]; out_z = (sum==0); out_c = carry out of the MSB slice (for subtraction, 1 = no borrow); out_v = carry into MSB XOR carry out of MSB.
REQ-023 DONE: out_sum and flags SHALL hold stable while out_valid && !out_ready.
REQ-024 DONE, on out_ready: clear out_valid and go to IDLE; out_sum and flags SHALL retain their values.
REQ-025 No new request SHALL be accepted in the cycle in which a result is consumed; minimum spacing between accepts is BEATS+2 cycles.
REQ-026 out_valid SHALL never be asserted in IDLE or RUN.

Reset
REQ-027 With rst high at a rising edge: state <= IDLE, beat <= 0, carry <= 0, out_valid <= 0, out_sum <= 0, all flags <= 0.
REQ-028 rst SHALL take priority over every handshake and FSM transition, in any state; a request aborted by reset SHALL produce no result.
REQ-029 in_ready SHALL be 0 while rst is high and SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Add 0x00000001 + 0xFFFFFFFF, out_ready=1 -> out_valid in cycle 5; sum=0x00000000; Z=1, C=1, N=0, V=0 (carry ripples across all slices).
REQ-031 Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000; N=1, V=1, C=0, Z=0.
REQ-032 Sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF; V=1, C=1, N=0; and sub 5 - 7 -> sum=0xFFFFFFFE; N=1, C=0, V=0.
REQ-033 Backpressure: out_ready=0 for 3 cycles after out_valid, with in_valid=1 and changing operands -> outputs stable, in_ready=0, one transfer on the out_ready edge, then in_ready=1 the next cycle.
REQ-034 rst pulsed for 1 cycle during RUN at beat 2 -> next cycle IDLE, out_valid=0, out_sum=0, flags=0; in_ready=1 after rst drops; no result ever emitted for the aborted operation.
REQ-035 Back-to-back: two requests held on in_valid, out_ready=1 -> second accept exactly BEATS+2 cycles after the first; each result is correct and independent.
